// File: rtl/bcd2bin_pkg.sv
// bcd2bin_pkg: shared constants, FSM state type and the invalid-digit helper
// for the sequential BCD-to-binary converter.
package bcd2bin_pkg;

  // Result width: four digits top out at 9999, which needs 14 bits.
  localparam int N_BITS    = 14;
  // Number of packed BCD digits handled per conversion.
  localparam int N_DIGITS  = 4;
  // Counter preload; OP runs ITER_LAST+1 = N_BITS shift iterations.
  localparam int ITER_LAST = 13;
  // Iteration counter width (must hold ITER_LAST).
  localparam int CNT_W     = 4;
  // Width of the packed BCD word {bcd3,bcd2,bcd1,bcd0}.
  localparam int BCD_W     = 4 * N_DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } bcd2bin_state_t;

  // True when any nibble of the packed BCD word holds A..F.
  function automatic logic has_bad_digit(input logic [BCD_W-1:0] bcd);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd2bin_digit_adj.sv
// bcd_digit_adj: one reverse double-dabble digit correction. After the right
// shift a digit of 8 or more has taken a half-weight bit from the digit above;
// subtracting 3 (modulo 16, no borrow out) restores a proper decimal digit.
module bcd_digit_adj (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // Conditional subtract-3 on a single nibble.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd8) digit_out = digit_in - 4'd3;
  end

endmodule

// File: rtl/bcd2bin.sv
// bcd2bin: sequential BCD-to-binary converter (reverse double dabble).
// Four BCD digits are captured on an accepted start, shifted through a
// 30-bit {bcd_reg, bin_reg} register for 14 cycles, and the 14-bit result is
// presented on bin with a one-cycle done_tick.
//
// Optional feature, macro BCD2BIN_ERR_CHECK_EN: flags input digits A..F at
// capture; the flag lands on err at completion and forces bin to 0.
// Without the macro err is tied low and no checking logic exists.
//
// Handshake: start is sampled only on a rising edge where ready=1; that edge
// captures the digits and drops ready. ready stays low through OP and DONE
// and rises again on the edge that leaves DONE. start seen while ready=0 is
// dropped, never queued, and never restarts the conversion in flight.
module bcd2bin
  import bcd2bin_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [3:0]           bcd3,
  input  logic [3:0]           bcd2,
  input  logic [3:0]           bcd1,
  input  logic [3:0]           bcd0,
  output logic                 ready,
  output logic                 done_tick,
  output logic [N_BITS-1:0]    bin,
  output logic                 err,
  output bcd2bin_state_t       dbg_state
);

  bcd2bin_state_t     state;
  logic [BCD_W-1:0]   bcd_reg;
  logic [N_BITS-1:0]  bin_reg;
  logic [CNT_W-1:0]   n;

  logic [BCD_W-1:0]   bcd_shift;
  logic [BCD_W-1:0]   bcd_adj;
  logic [N_BITS-1:0]  bin_shift;

  assign dbg_state = state;

  // Right shift of the concatenation: the BCD LSB drops into the binary MSB.
  assign bcd_shift = {1'b0, bcd_reg[BCD_W-1:1]};
  assign bin_shift = {bcd_reg[0], bin_reg[N_BITS-1:1]};

  // Per-digit correction applied to the freshly shifted BCD word.
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (bcd_shift[4*g +: 4]),
      .digit_out (bcd_adj[4*g +: 4])
    );
  end

`ifdef BCD2BIN_ERR_CHECK_EN
  logic bad_flag;
`else
  assign err = 1'b0;
`endif

  // Control FSM, iteration counter, shift datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bcd_reg   <= '0;
      bin_reg   <= '0;
      n         <= '0;
      bin       <= '0;
      done_tick <= 1'b0;
      ready     <= 1'b1;
`ifdef BCD2BIN_ERR_CHECK_EN
      bad_flag  <= 1'b0;
      err       <= 1'b0;
`endif
    end else begin
      done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bcd_reg <= {bcd3, bcd2, bcd1, bcd0};
            bin_reg <= '0;
            n       <= CNT_W'(ITER_LAST);
            ready   <= 1'b0;
            state   <= OP;
`ifdef BCD2BIN_ERR_CHECK_EN
            bad_flag <= has_bad_digit({bcd3, bcd2, bcd1, bcd0});
`endif
          end
        end
        OP: begin
          bcd_reg <= bcd_adj;
          bin_reg <= bin_shift;
          if (n == '0) begin
            // Final iteration: publish the result so it is visible during DONE.
            state     <= DONE;
            done_tick <= 1'b1;
`ifdef BCD2BIN_ERR_CHECK_EN
            err       <= bad_flag;
            bin       <= bad_flag ? '0 : bin_shift;
`else
            bin       <= bin_shift;
`endif
          end else begin
            n <= n - 1'b1;
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
